// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-channel request arbiter in front of a shared combinational ALU
module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_f,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_f,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       alu_f_q, alu_f_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             grant0, grant1;

    // On contention, round-robin favours whichever channel was not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if ((PRIO_MODE != 0) || last_grant_q) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_f_d      = alu_f_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_y_d      = rsp_y_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    alu_a_d      = req0_a;
                    alu_b_d      = req0_b;
                    alu_f_d      = req0_f;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (req1_ready) begin
                    alu_a_d      = req1_a;
                    alu_b_d      = req1_b;
                    alu_f_d      = req1_f;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_y_d     = alu_y;
                rsp_zero_d  = alu_zero;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_f_q      <= 3'b000;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_f_q      <= alu_f_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_y_q      <= rsp_y_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_f     = alu_f_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench for alu_arbiter, round-robin and fixed-priority instances
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_f = '0, req1_f = '0;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, busy, alu_zero;
    logic [31:0] alu_a, alu_b, alu_y, rsp_y;
    logic [2:0]  alu_f;
    logic        p_req0_ready, p_req1_ready, p_rsp_valid, p_rsp_id, p_rsp_zero, p_busy, p_alu_zero;
    logic [31:0] p_alu_a, p_alu_b, p_alu_y, p_rsp_y;
    logic [2:0]  p_alu_f;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b100:  return a & ~b;
            3'b101:  return a | ~b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign alu_y      = alu_model(alu_a, alu_b, alu_f);
    assign alu_zero   = (alu_y == 32'd0);
    assign p_alu_y    = alu_model(p_alu_a, p_alu_b, p_alu_f);
    assign p_alu_zero = (p_alu_y == 32'd0);

    alu_arbiter #(.WIDTH(32), .PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_zero(rsp_zero), .busy(busy)
    );

    alu_arbiter #(.WIDTH(32), .PRIO_MODE(1)) dut_p (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(p_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(p_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_f(p_alu_f), .alu_y(p_alu_y), .alu_zero(p_alu_zero),
        .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(p_rsp_id), .rsp_y(p_rsp_y),
        .rsp_zero(p_rsp_zero), .busy(p_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int got;
        int p_got;
        logic p_r1_seen;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_f", alu_f, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_ready0", req0_ready, 0);
        rst = 1'b0;

        // Single ch0 add
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h11111111; req0_b = 32'h88888888; req0_f = 3'b010;
        #1;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_busy_idle", busy, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("t1_exec_busy", busy, 1);
        chk("t1_exec_rsp_valid", rsp_valid, 0);
        chk("t1_alu_a", alu_a, 32'h11111111);
        chk("t1_exec_ready0", req0_ready, 0);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_y", rsp_y, 32'h99999999);
        chk("t1_rsp_zero", rsp_zero, 0);
        chk("t1_resp_busy", busy, 1);
        @(negedge clk);
        chk("t1_done_valid", rsp_valid, 0);
        chk("t1_done_busy", busy, 0);
        chk("t1_hold_y", rsp_y, 32'h99999999);
        chk("t1_hold_alu_a", alu_a, 32'h11111111);

        // Single ch1 subtract to zero
        req1_valid = 1'b1; req1_a = 32'h12345678; req1_b = 32'h12345678; req1_f = 3'b110;
        #1;
        chk("t2_ready1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_id", rsp_id, 1);
        chk("t2_rsp_y", rsp_y, 0);
        chk("t2_rsp_zero", rsp_zero, 1);
        @(negedge clk);

        // Both valid continuously: RR alternates, fixed priority always picks ch0
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_f = 3'b010;
        req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd3; req1_f = 3'b011;
        got = 0; p_got = 0; p_r1_seen = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            chk("rr_one_ready", req0_ready && req1_ready, 0);
            if (p_req1_ready) p_r1_seen = 1'b1;
            if (rsp_valid) begin
                chk("rr_id", rsp_id, got % 2);
                chk("rr_y", rsp_y, (got % 2 == 0) ? 32'd8 : 32'hDEADBEEF);
                got++;
            end
            if (p_rsp_valid) begin
                chk("prio_id", p_rsp_id, 0);
                chk("prio_y", p_rsp_y, 32'd8);
                p_got++;
            end
            if (got == 6) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_count", got, 6);
        chk("prio_count", p_got, 6);
        chk("prio_ready1_never", p_r1_seen, 0);
        @(negedge clk);

        // Backpressure with a second ch0 request waiting
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_f = 3'b001;
        #1;
        chk("bp_ready0", req0_ready, 1);
        @(negedge clk);
        req0_a = 32'd1; req0_b = 32'd2; req0_f = 3'b010;
        @(negedge clk);
        chk("bp_rsp_valid", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_y", rsp_y, 32'd7);
            chk("bp_hold_id", rsp_id, 0);
            chk("bp_ready0_low", req0_ready, 0);
            chk("bp_ready1_low", req1_ready, 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready0_in_resp", req0_ready, 0);
        @(negedge clk);
        chk("bp_released", rsp_valid, 0);
        chk("bp_ready0_after", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("bp2_rsp_valid", rsp_valid, 1);
        chk("bp2_rsp_y", rsp_y, 32'd3);
        @(negedge clk);

        // Asynchronous reset in EXEC
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_f = 3'b010;
        @(negedge clk);
        req0_valid = 1'b0;
        chk("ar_exec_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_alu_a", alu_a, 0);
        chk("ar_rsp_y", rsp_y, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_no_rsp", rsp_valid, 0);
        end
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_f = 3'b010;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_f = 3'b010;
        #1;
        chk("ar_pref_ready0", req0_ready, 1);
        chk("ar_pref_ready1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("ar_next_valid", rsp_valid, 1);
        chk("ar_next_id", rsp_id, 0);
        chk("ar_next_y", rsp_y, 32'd30);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
